// File: rtl/reset_sequencer.sv
// Staged reset sequencer: holds core and peripherals in reset, releases the core first,
// counts watchdog restarts and locks out after too many, and accepts a synchronised request.
module reset_sequencer #(
   parameter int unsigned Hold_Cycles   = 16,
   parameter int unsigned Stage_Cycles  = 8,
   parameter int unsigned Max_Retries   = 3,
   parameter int unsigned Stable_Cycles = 1000
) (
   input  logic       ipClk,
   input  logic       ipReset,
   input  logic       ipError,
   input  logic       ipRequest,
   input  logic       ipClear,
   output logic       opCoreReset,
   output logic       opPeriphReset,
   output logic [3:0] opRetryCount,
   output logic       opLockout,
   output logic [1:0] opCause
);

   localparam int unsigned HoldW   = $clog2(Hold_Cycles + 1);
   localparam int unsigned StageW  = $clog2(Stage_Cycles + 1);
   localparam int unsigned StableW = $clog2(Stable_Cycles + 1);

   localparam logic [HoldW-1:0]   HoldLoad   = HoldW'(Hold_Cycles - 1);
   localparam logic [StageW-1:0]  StageLoad  = StageW'(Stage_Cycles - 1);
   localparam logic [StableW-1:0] StableMax  = StableW'(Stable_Cycles);
   localparam logic [4:0]         RetryLimit = 5'(Max_Retries);

   localparam logic [1:0] CausePowerOn  = 2'b00;
   localparam logic [1:0] CauseWatchdog = 2'b01;
   localparam logic [1:0] CauseRequest  = 2'b10;
   localparam logic [1:0] CauseClear    = 2'b11;

   typedef enum logic [1:0] {StHold, StStage, StRun, StLock} stateType;

   stateType           state;
   logic [HoldW-1:0]   holdCnt;
   logic [StageW-1:0]  stageCnt;
   logic [StableW-1:0] stableCnt;
   logic [2:0]         reqSync;

   logic       reqEvent;
   logic [4:0] retryPlus;
   logic [3:0] retrySat;
   logic       retryExhausted;

   // Two synchroniser flops, then a third flop for rising-edge detection.
   assign reqEvent       = reqSync[1] & ~reqSync[2];
   assign retryPlus      = {1'b0, opRetryCount} + 5'd1;
   assign retrySat       = (opRetryCount == 4'hF) ? 4'hF : retryPlus[3:0];
   assign retryExhausted = (retryPlus >= RetryLimit);

   always_ff @(posedge ipClk or negedge ipReset) begin
      if (!ipReset) begin
         state         <= StHold;
         holdCnt       <= HoldLoad;
         stageCnt      <= StageLoad;
         stableCnt     <= '0;
         reqSync       <= '0;
         opCoreReset   <= 1'b1;
         opPeriphReset <= 1'b1;
         opRetryCount  <= 4'd0;
         opLockout     <= 1'b0;
         opCause       <= CausePowerOn;
      end else begin
         reqSync <= {reqSync[1:0], ipRequest};
         unique case (state)
            StHold: begin
               if (holdCnt == '0) begin
                  state       <= StStage;
                  stageCnt    <= StageLoad;
                  opCoreReset <= 1'b0;
               end else begin
                  holdCnt <= holdCnt - HoldW'(1);
               end
            end
            StStage: begin
               if (stageCnt == '0) begin
                  state         <= StRun;
                  stableCnt     <= '0;
                  opPeriphReset <= 1'b0;
               end else begin
                  stageCnt <= stageCnt - StageW'(1);
               end
            end
            StRun: begin
               if (ipError) begin
                  opRetryCount  <= retrySat;
                  opCause       <= CauseWatchdog;
                  opCoreReset   <= 1'b1;
                  opPeriphReset <= 1'b1;
                  holdCnt       <= HoldLoad;
                  stableCnt     <= '0;
                  if (retryExhausted) begin
                     state     <= StLock;
                     opLockout <= 1'b1;
                  end else begin
                     state <= StHold;
                  end
               end else if (reqEvent) begin
                  state         <= StHold;
                  opCause       <= CauseRequest;
                  opCoreReset   <= 1'b1;
                  opPeriphReset <= 1'b1;
                  holdCnt       <= HoldLoad;
                  stableCnt     <= '0;
               end else begin
                  if (ipClear || (stableCnt == StableMax)) begin
                     opRetryCount <= 4'd0;
                  end
                  // Saturate rather than wrap so a long-running system stays cleared.
                  if (stableCnt != StableMax) begin
                     stableCnt <= stableCnt + StableW'(1);
                  end
               end
            end
            StLock: begin
               if (ipClear) begin
                  state        <= StHold;
                  holdCnt      <= HoldLoad;
                  opRetryCount <= 4'd0;
                  opLockout    <= 1'b0;
                  opCause      <= CauseClear;
               end
            end
            default: begin
               state <= StHold;
               holdCnt <= HoldLoad;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with short timing parameters: a vector table
// for the main sequence plus hand-written multi-cycle corner cases.
module tb_reset_sequencer;

   logic       ipClk = 1'b0;
   logic       ipReset = 1'b0;
   logic       ipError = 1'b0;
   logic       ipRequest = 1'b0;
   logic       ipClear = 1'b0;
   logic       opCoreReset;
   logic       opPeriphReset;
   logic [3:0] opRetryCount;
   logic       opLockout;
   logic [1:0] opCause;

   int nChecks = 0;
   int nFails  = 0;

   reset_sequencer #(
      .Hold_Cycles  (4),
      .Stage_Cycles (3),
      .Max_Retries  (2),
      .Stable_Cycles(10)
   ) dut (
      .ipClk        (ipClk),
      .ipReset      (ipReset),
      .ipError      (ipError),
      .ipRequest    (ipRequest),
      .ipClear      (ipClear),
      .opCoreReset  (opCoreReset),
      .opPeriphReset(opPeriphReset),
      .opRetryCount (opRetryCount),
      .opLockout    (opLockout),
      .opCause      (opCause)
   );

   always #5 ipClk = ~ipClk;

   typedef struct {
      logic       rst;
      logic       err;
      logic       req;
      logic       clr;
      logic [8:0] exp;
   } rowType;

   rowType rows[$];

   function automatic logic [8:0] pk(input logic core, input logic per, input logic [3:0] retry,
                                     input logic lock, input logic [1:0] cause);
      return {core, per, retry, lock, cause};
   endfunction

   task automatic addRow(input logic rst, input logic err, input logic req, input logic clr,
                         input logic [8:0] exp);
      rowType r;
      r.rst = rst; r.err = err; r.req = req; r.clr = clr; r.exp = exp;
      rows.push_back(r);
   endtask

   task automatic step();
      @(posedge ipClk);
      #1;
   endtask

   task automatic chk(input string name, input logic [8:0] exp);
      logic [8:0] act;
      act = {opCoreReset, opPeriphReset, opRetryCount, opLockout, opCause};
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got core=%0b periph=%0b retry=%0d lock=%0b cause=%0d, want core=%0b periph=%0b retry=%0d lock=%0b cause=%0d",
                  name, act[8], act[7], act[6:3], act[2], act[1:0],
                  exp[8], exp[7], exp[6:3], exp[2], exp[1:0]);
      end
   endtask

   // Called one cycle after HOLD was entered: three more HOLD cycles, three STAGE, then RUN.
   task automatic checkSeq(input string name, input logic [3:0] retry, input logic [1:0] cause);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("%s hold%0d", name, i), pk(1'b1, 1'b1, retry, 1'b0, cause));
      end
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("%s stage%0d", name, i), pk(1'b0, 1'b1, retry, 1'b0, cause));
      end
      step();
      chk($sformatf("%s run", name), pk(1'b0, 1'b0, retry, 1'b0, cause));
   endtask

   initial begin
      // Reset held, then release and the 4+3 sequence.
      repeat (2) addRow(0, 0, 0, 0, pk(1, 1, 0, 0, 0));
      repeat (3) addRow(1, 0, 0, 0, pk(1, 1, 0, 0, 0));
      repeat (3) addRow(1, 0, 0, 0, pk(0, 1, 0, 0, 0));
      repeat (2) addRow(1, 0, 0, 0, pk(0, 0, 0, 0, 0));
      // First watchdog restart.
      addRow(1, 1, 0, 0, pk(1, 1, 1, 0, 1));
      repeat (3) addRow(1, 0, 0, 0, pk(1, 1, 1, 0, 1));
      repeat (3) addRow(1, 0, 0, 0, pk(0, 1, 1, 0, 1));
      addRow(1, 0, 0, 0, pk(0, 0, 1, 0, 1));
      // Second watchdog restart locks out.
      addRow(1, 1, 0, 0, pk(1, 1, 2, 1, 1));
      // Errors and requests are ignored in LOCK.
      addRow(1, 1, 0, 0, pk(1, 1, 2, 1, 1));
      repeat (4) addRow(1, 0, 1, 0, pk(1, 1, 2, 1, 1));
      repeat (3) addRow(1, 0, 0, 0, pk(1, 1, 2, 1, 1));
      // Clear leaves LOCK; errors during HOLD/STAGE are ignored.
      addRow(1, 0, 0, 1, pk(1, 1, 0, 0, 3));
      addRow(1, 1, 0, 0, pk(1, 1, 0, 0, 3));
      repeat (2) addRow(1, 0, 0, 0, pk(1, 1, 0, 0, 3));
      addRow(1, 0, 0, 0, pk(0, 1, 0, 0, 3));
      addRow(1, 1, 0, 0, pk(0, 1, 0, 0, 3));
      addRow(1, 0, 0, 0, pk(0, 1, 0, 0, 3));
      repeat (2) addRow(1, 0, 0, 0, pk(0, 0, 0, 0, 3));

      #1;
      foreach (rows[i]) begin
         ipReset   = rows[i].rst;
         ipError   = rows[i].err;
         ipRequest = rows[i].req;
         ipClear   = rows[i].clr;
         step();
         chk($sformatf("row%0d", i), rows[i].exp);
      end
      ipError = 0; ipRequest = 0; ipClear = 0;

      // Request latency: edge detected on the third clock after the input rises.
      ipRequest = 1;
      step(); chk("req lat1", pk(0, 0, 0, 0, 3));
      step(); chk("req lat2", pk(0, 0, 0, 0, 3));
      step(); chk("req lat3", pk(1, 1, 0, 0, 2));
      checkSeq("req seq", 4'd0, 2'd2);
      // Held request gives only one restart.
      for (int i = 0; i < 20; i++) begin
         step(); chk($sformatf("req held%0d", i), pk(0, 0, 0, 0, 2));
      end
      ipRequest = 0;
      repeat (3) step();

      // Stable RUN period clears the retry count; the next error restarts rather than locks.
      ipError = 1; step(); ipError = 0;
      chk("stab err1", pk(1, 1, 1, 0, 1));
      checkSeq("stab seq1", 4'd1, 2'd1);
      repeat (9) step();
      chk("stab early", pk(0, 0, 1, 0, 1));
      repeat (3) step();
      chk("stab cleared", pk(0, 0, 0, 0, 1));
      ipError = 1; step(); ipError = 0;
      chk("stab err2", pk(1, 1, 1, 0, 1));
      checkSeq("stab seq2", 4'd1, 2'd1);

      // Clear in RUN zeros the count without a restart.
      ipClear = 1; step(); ipClear = 0;
      chk("run clear", pk(0, 0, 0, 0, 1));

      // Error and request event in the same cycle: watchdog wins.
      ipRequest = 1;
      step(); step();
      ipError = 1; step(); ipError = 0;
      chk("simul", pk(1, 1, 1, 0, 1));
      checkSeq("simul seq", 4'd1, 2'd1);
      ipRequest = 0;
      repeat (3) step();

      // Asynchronous reset during STAGE.
      ipRequest = 1;
      repeat (3) step();
      chk("req2 hold", pk(1, 1, 1, 0, 2));
      ipRequest = 0;
      repeat (3) step();
      step(); chk("req2 stage", pk(0, 1, 1, 0, 2));
      #2 ipReset = 0;
      #1 chk("async stage", pk(1, 1, 0, 0, 0));
      step();
      ipReset = 1;
      checkSeq("restart", 4'd0, 2'd0);

      // Asynchronous reset from LOCK clears the lockout.
      ipError = 1; step(); ipError = 0;
      chk("lock err1", pk(1, 1, 1, 0, 1));
      checkSeq("lock seq", 4'd1, 2'd1);
      ipError = 1; step(); ipError = 0;
      chk("lock entry", pk(1, 1, 2, 1, 1));
      #2 ipReset = 0;
      #1 chk("async lock", pk(1, 1, 0, 0, 0));
      step();
      ipReset = 1;
      checkSeq("restart2", 4'd0, 2'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter Hold_Cycles, default 16: cycles both reset outputs are held in HOLD; legal range 1..65535.
REQ-002 Parameter Stage_Cycles, default 8: cycles core is released before peripherals in STAGE; legal range 1..65535.
REQ-003 Parameter Max_Retries, default 3: number of watchdog-triggered restarts that forces LOCK; legal range 1..15.
REQ-004 Parameter Stable_Cycles, default 1000: error-free RUN cycles that clear the retry count; legal range 1..2^24-1.
REQ-005 ipClk  input  1  system clock; all logic on rising edge.
REQ-006 ipReset  input  1  asynchronous, active-low reset.
REQ-007 ipError  input  1  watchdog timeout flag, synchronous to ipClk, level.
REQ-008 ipRequest  input  1  asynchronous software/button reset request, active-high.
REQ-009 ipClear  input  1  synchronous lockout/retry-count clear, single-cycle pulse.
REQ-010 opCoreReset  output  1  active-high reset to core logic, including the watchdog.
REQ-011 opPeriphReset  output  1  active-high reset to peripherals.
REQ-012 opRetryCount  output  4  watchdog restarts since the last clear.
REQ-013 opLockout  output  1  high while in LOCK.
REQ-014 opCause  output  2  cause of last reset: 00 power-on, 01 watchdog, 10 request, 11 clear.

Function
REQ-015 The block SHALL implement the states HOLD, STAGE, RUN and LOCK, registered, one-hot or binary.
REQ-016 HOLD SHALL assert both resets and SHALL last exactly Hold_Cycles cycles, then go to STAGE.
REQ-017 STAGE SHALL assert opPeriphReset only and SHALL last exactly Stage_Cycles cycles, then go to RUN.
REQ-018 RUN SHALL deassert both resets.
REQ-019 LOCK SHALL assert both resets and opLockout, and SHALL remain until ipClear.
REQ-020 All outputs SHALL be registered, with no combinational path from any input.
REQ-021 ipRequest SHALL pass through a two-flop synchroniser followed by a rising-edge detect; the request event is the detected edge, giving 3 cycles latency from the input edge.
REQ-022 In RUN with ipError=1 and opRetryCount+1 < Max_Retries: next state HOLD, opRetryCount increments, opCause=01.
REQ-023 In RUN with ipError=1 and opRetryCount+1 >= Max_Retries: next state LOCK, opRetryCount increments (saturating at 15), opCause=01.
REQ-024 In RUN with a request event and ipError=0: next state HOLD, opRetryCount unchanged, opCause=10.
REQ-025 In RUN, ipError SHALL take priority over a simultaneous request event and over ipClear.
REQ-026 In HOLD and STAGE, ipError and request events SHALL be ignored; the held reset clears the watchdog.
REQ-027 In LOCK, ipClear SHALL cause: next state HOLD, opRetryCount=0, opCause=11. ipError and requests SHALL be ignored in LOCK.
REQ-028 In RUN, ipClear with ipError=0 SHALL zero opRetryCount without changing state.
REQ-029 A stable counter SHALL count consecutive RUN cycles with ipError=0 and SHALL reset on leaving RUN.
REQ-030 When the stable counter reaches Stable_Cycles, opRetryCount SHALL become 0 on the next cycle.
REQ-031 Hold, stage and stable counters SHALL be sized to their parameter with clog2 and SHALL NOT wrap.

Reset
REQ-032 While ipReset=0: state HOLD, hold counter reloaded, opCoreReset=1, opPeriphReset=1, opRetryCount=0, opLockout=0, opCause=00, synchroniser flops 0.
REQ-033 Reset assertion mid-sequence, including from LOCK, SHALL return the block to HOLD and clear the lockout.
REQ-034 The full HOLD timing SHALL restart on release of ipReset.

Verification (Hold_Cycles=4, Stage_Cycles=3, Max_Retries=2, Stable_Cycles=10)
REQ-035 Release ipReset -> opCoreReset high 4 cycles, then low; opPeriphReset low 3 cycles later; opCause=00.
REQ-036 In RUN, pulse ipError 1 cycle -> HOLD, opRetryCount=1, opCause=01; a second ipError after the sequence -> LOCK, opLockout=1, opRetryCount=2.
REQ-037 In LOCK, pulse ipError and ipRequest -> no change; pulse ipClear -> HOLD, opRetryCount=0, opCause=11, full 4+3 cycle sequence.
REQ-038 ipRequest rising edge in RUN -> opCoreReset high on 3rd cycle after the edge, opCause=10, opRetryCount unchanged; ipRequest held high -> only one restart.
REQ-039 After one watchdog restart, 10 error-free RUN cycles -> opRetryCount returns to 0; a following single ipError -> HOLD, not LOCK.
REQ-040 ipError and ipRequest edge in the same RUN cycle -> opCause=01, count increments; ipReset pulled low during STAGE -> both resets high immediately (asynchronous).
